// File: rtl/lcd_bus_arbiter_if.sv
// lcd_bus_arbiter_if: groups the two requester handshakes and the LCD pin
// bundle so the arbiter and its surroundings connect with a single port.
// The slave modport is the arbiter's view; the master modport is the view
// of whatever drives the requests and observes the pins.
interface lcd_bus_arbiter_if;
    logic       req0;
    logic       rs0;
    logic [7:0] data0;
    logic       ack0;
    logic       req1;
    logic       rs1;
    logic [7:0] data1;
    logic       ack1;
    logic       busy;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_db;
    logic       lcd_rst;

    modport slave (
        input  req0, rs0, data0, req1, rs1, data1,
        output ack0, ack1, busy, lcd_en, lcd_rs, lcd_rw, lcd_db, lcd_rst
    );

    modport master (
        output req0, rs0, data0, req1, rs1, data1,
        input  ack0, ack1, busy, lcd_en, lcd_rs, lcd_rw, lcd_db, lcd_rst
    );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: shares the 8-bit parallel LCD write bus between two
// requesters. Each grant captures one command/data byte, then the FSM walks
// through setup, enable pulse, hold and the controller execution delay
// before the bus is offered again. Ties are broken round-robin.
// Optional feature macro: LCD_HW_RESET_EN -- after rst_n releases, lcd_rst
// is held low for RST_CYC cycles (busy high, requests ignored) before IDLE.
module lcd_bus_arbiter #(
    parameter int SETUP_CYC = 4,
    parameter int PULSE_CYC = 16,
    parameter int HOLD_CYC  = 4,
    parameter int EXEC_CYC  = 2000,
    parameter int LONG_CYC  = 80000,
    parameter int RST_CYC   = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    lcd_bus_arbiter_if.slave bus
);

    // One shared down-counter must hold the largest (N-1) reload value.
    localparam int MAX_SP   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_HE   = (HOLD_CYC > EXEC_CYC) ? HOLD_CYC : EXEC_CYC;
    localparam int MAX_LR   = (LONG_CYC > RST_CYC) ? LONG_CYC : RST_CYC;
    localparam int MAX_SPHE = (MAX_SP > MAX_HE) ? MAX_SP : MAX_HE;
    localparam int MAX_CYC  = (MAX_SPHE > MAX_LR) ? MAX_SPHE : MAX_LR;
    localparam int CNT_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LOAD  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(LONG_CYC - 1);
`ifdef LCD_HW_RESET_EN
    localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RST_CYC - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
`ifdef LCD_HW_RESET_EN
        ,
        ST_RESET
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             busy_q, busy_d;
    logic             lcdEn_q, lcdEn_d;
    logic             lcdRs_q, lcdRs_d;
    logic [7:0]       lcdDb_q, lcdDb_d;
    logic             lastGrant_q, lastGrant_d;
`ifdef LCD_HW_RESET_EN
    logic             lcdRst_q, lcdRst_d;
`endif

    logic cntZero;
    logic isLong;
    logic grant1;

    assign cntZero = (cnt_q == '0);

    // Clear and return-home commands need the long controller delay.
    assign isLong = !lcdRs_q &&
                    ((lcdDb_q == 8'h01) || (lcdDb_q == 8'h02) || (lcdDb_q == 8'h03));

    // Register all state and outputs; reset kills any strobe in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef LCD_HW_RESET_EN
            state_q  <= ST_RESET;
            cnt_q    <= RST_LOAD;
            busy_q   <= 1'b1;
            lcdRst_q <= 1'b0;
`else
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
`endif
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            lcdEn_q     <= 1'b0;
            lcdRs_q     <= 1'b0;
            lcdDb_q     <= 8'h00;
            lastGrant_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            lcdEn_q     <= lcdEn_d;
            lcdRs_q     <= lcdRs_d;
            lcdDb_q     <= lcdDb_d;
            lastGrant_q <= lastGrant_d;
`ifdef LCD_HW_RESET_EN
            lcdRst_q    <= lcdRst_d;
`endif
        end
    end

    // Next-state, arbitration and next-output values for the strobe sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        lcdEn_d     = lcdEn_q;
        lcdRs_d     = lcdRs_q;
        lcdDb_d     = lcdDb_q;
        lastGrant_d = lastGrant_q;
        grant1      = 1'b0;
`ifdef LCD_HW_RESET_EN
        lcdRst_d    = lcdRst_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // Requester 1 wins if alone, or on a tie when 0 went last.
                    grant1      = bus.req1 && (!bus.req0 || !lastGrant_q);
                    lastGrant_d = grant1;
                    ack0_d      = !grant1;
                    ack1_d      = grant1;
                    lcdRs_d     = grant1 ? bus.rs1 : bus.rs0;
                    lcdDb_d     = grant1 ? bus.data1 : bus.data0;
                    busy_d      = 1'b1;
                    state_d     = ST_SETUP;
                    cnt_d       = SETUP_LOAD;
                end
            end

            ST_SETUP: begin
                if (cntZero) begin
                    state_d = ST_PULSE;
                    cnt_d   = PULSE_LOAD;
                    lcdEn_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_PULSE: begin
                if (cntZero) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                    lcdEn_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_HOLD: begin
                if (cntZero) begin
                    state_d = ST_WAIT;
                    cnt_d   = isLong ? LONG_LOAD : EXEC_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_WAIT: begin
                if (cntZero) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

`ifdef LCD_HW_RESET_EN
            ST_RESET: begin
                if (cntZero) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    busy_d   = 1'b0;
                    lcdRst_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
                lcdEn_d = 1'b0;
            end
        endcase
    end

    assign bus.ack0   = ack0_q;
    assign bus.ack1   = ack1_q;
    assign bus.busy   = busy_q;
    assign bus.lcd_en = lcdEn_q;
    assign bus.lcd_rs = lcdRs_q;
    assign bus.lcd_db = lcdDb_q;
    assign bus.lcd_rw = 1'b0;
`ifdef LCD_HW_RESET_EN
    assign bus.lcd_rst = lcdRst_q;
`else
    assign bus.lcd_rst = 1'b1;
`endif

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: self-checking bench for lcd_bus_arbiter. A
// transaction-level reference model (grant time, age, transaction length)
// predicts every output each cycle; directed scenarios add fixed timing
// expectations.
module tb_lcd_bus_arbiter;

    localparam int S = 2;
    localparam int P = 3;
    localparam int H = 2;
    localparam int E = 5;
    localparam int L = 20;
    localparam int R = 8;
`ifdef LCD_HW_RESET_EN
    localparam bit HW = 1'b1;
`else
    localparam bit HW = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    lcd_bus_arbiter_if bus();

    lcd_bus_arbiter #(
        .SETUP_CYC (S),
        .PULSE_CYC (P),
        .HOLD_CYC  (H),
        .EXEC_CYC  (E),
        .LONG_CYC  (L),
        .RST_CYC   (R)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: a transaction is a grant followed by mLen busy cycles.
    bit         mActive    = 1'b0;
    int         mAge       = 0;
    int         mLen       = 0;
    int         mWho       = 0;
    bit         mLastGrant = 1'b1;
    logic       mRs        = 1'b0;
    logic [7:0] mDb        = 8'h00;
    int         mRstLeft   = HW ? R : 0;

    // Advance the model one clock, or return it to its reset state.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mActive    = 1'b0;
            mAge       = 0;
            mLen       = 0;
            mWho       = 0;
            mLastGrant = 1'b1;
            mRs        = 1'b0;
            mDb        = 8'h00;
            mRstLeft   = HW ? R : 0;
        end else if (mRstLeft > 0) begin
            mRstLeft--;
        end else if (mActive) begin
            mAge++;
            if (mAge == mLen) mActive = 1'b0;
        end else if (bus.req0 || bus.req1) begin
            if (bus.req0 && bus.req1) mWho = mLastGrant ? 0 : 1;
            else                      mWho = bus.req1 ? 1 : 0;
            mLastGrant = (mWho == 1);
            mRs        = (mWho == 1) ? bus.rs1 : bus.rs0;
            mDb        = (mWho == 1) ? bus.data1 : bus.data0;
            mLen       = S + P + H + ((!mRs && mDb >= 8'h01 && mDb <= 8'h03) ? L : E);
            mActive    = 1'b1;
            mAge       = 0;
        end
    end

    function automatic logic [14:0] expVec();
        logic ack;
        ack = mActive && (mAge == 0);
        return {ack && (mWho == 0), ack && (mWho == 1), mActive || (mRstLeft > 0),
                mActive && (mAge >= S) && (mAge < S + P), mRs, 1'b0, (mRstLeft == 0), mDb};
    endfunction

    function automatic logic [14:0] dutVec();
        return {bus.ack0, bus.ack1, bus.busy, bus.lcd_en, bus.lcd_rs,
                bus.lcd_rw, bus.lcd_rst, bus.lcd_db};
    endfunction

    function automatic logic [7:0] randByte();
        if ($urandom_range(3, 0) == 0) return 8'($urandom_range(3, 1));
        return 8'($urandom_range(255, 0));
    endfunction

    task automatic applyReset();
        rst_n = 1'b0;
        bus.req0 = 1'b0; bus.rs0 = 1'b0; bus.data0 = 8'h00;
        bus.req1 = 1'b0; bus.rs1 = 1'b0; bus.data1 = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic applyStimulus(input int who, input logic rs, input logic [7:0] data);
        if (who == 0) begin bus.req0 = 1'b1; bus.rs0 = rs; bus.data0 = data; end
        else          begin bus.req1 = 1'b1; bus.rs1 = rs; bus.data1 = data; end
    endtask

    task automatic waitIdle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy !== 1'b0) begin
            checks++; failures++;
            $display("[TB] FAIL idle_timeout: busy=%b after %0d cycles, required 0", bus.busy, n);
        end
    endtask

    task automatic test_reset();
        logic [14:0] want;
        want = {1'b0, 1'b0, HW, 1'b0, 1'b0, 1'b0, !HW, 8'h00};
        checks++;
        if (dutVec() !== want) begin
            failures++;
            $display("[TB] FAIL reset_values: got %h required %h", dutVec(), want);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (dutVec() !== expVec()) begin
                failures++;
                $display("[TB] FAIL reset_idle_vec cycle %0d: got %h required %h", c, dutVec(), expVec());
            end
        end
    endtask

`ifdef LCD_HW_RESET_EN
    task automatic test_hw_reset();
        int lowCount = 0;
        int rstRise  = -1;
        int ackIdx   = -1;
        rst_n = 1'b0;
        applyStimulus(0, 1'b1, 8'h33);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.lcd_rst === 1'b0 && bus.busy === 1'b1) lowCount++;
            if (bus.lcd_rst === 1'b1 && rstRise < 0) rstRise = c;
            if (bus.ack0 === 1'b1 && ackIdx < 0) begin ackIdx = c; bus.req0 = 1'b0; end
        end
        checks++;
        if (lowCount != R) begin
            failures++;
            $display("[TB] FAIL hw_reset_low: got %0d cycles required %0d", lowCount, R);
        end
        checks++;
        if (ackIdx != rstRise + 1 || rstRise != R) begin
            failures++;
            $display("[TB] FAIL hw_reset_ack: ack at %0d rise at %0d, required %0d and %0d", ackIdx, rstRise, R + 1, R);
        end
    endtask
`endif

    task automatic test_single_write();
        int ackCyc[$];
        int enFirst = -1;
        int enCount = 0;
        int busyCount = 0;
        int gap;
        logic rsAtAck = 1'b0;
        logic [7:0] dbAtAck = 8'h00;
        waitIdle();
        applyStimulus(0, 1'b1, 8'h41);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            checks++;
            if (dutVec() !== expVec()) begin
                failures++;
                $display("[TB] FAIL single_write_vec cycle %0d: got %h required %h", c, dutVec(), expVec());
            end
            if (bus.ack0 === 1'b1) begin
                ackCyc.push_back(c);
                if (ackCyc.size() == 1) begin
                    rsAtAck = bus.lcd_rs; dbAtAck = bus.lcd_db; bus.data0 = 8'h42;
                end else begin
                    bus.req0 = 1'b0;
                end
            end
            if (ackCyc.size() == 1) begin
                if (bus.lcd_en === 1'b1) begin
                    if (enFirst < 0) enFirst = c;
                    enCount++;
                end
                if (bus.busy === 1'b1) busyCount++;
            end
        end
        bus.req0 = 1'b0;
        gap = (ackCyc.size() >= 2) ? ackCyc[1] - ackCyc[0] : -1;
        checks++;
        if (ackCyc.size() < 1 || ackCyc[0] != 1) begin
            failures++;
            $display("[TB] FAIL single_ack_latency: acks seen %0d, required first at cycle 1", ackCyc.size());
        end
        checks++;
        if ({rsAtAck, dbAtAck} !== {1'b1, 8'h41}) begin
            failures++;
            $display("[TB] FAIL single_bus: got rs=%b db=%h required rs=1 db=41", rsAtAck, dbAtAck);
        end
        checks++;
        if (ackCyc.size() < 1 || enFirst - ackCyc[0] != S || enCount != P) begin
            failures++;
            $display("[TB] FAIL single_strobe: first=%0d count=%0d required offset %0d count %0d", enFirst, enCount, S, P);
        end
        checks++;
        if (busyCount != 12) begin
            failures++;
            $display("[TB] FAIL single_busy: got %0d required 12", busyCount);
        end
        checks++;
        if (gap != 13) begin
            failures++;
            $display("[TB] FAIL single_period: got %0d required 13", gap);
        end
    endtask

    task automatic test_long_command();
        logic [7:0] bytes [2] = '{8'h01, 8'h38};
        int         wantB [2] = '{27, 12};
        for (int k = 0; k < 2; k++) begin
            int busyCount = 0;
            int acks = 0;
            waitIdle();
            applyStimulus(1, 1'b0, bytes[k]);
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk);
                checks++;
                if (dutVec() !== expVec()) begin
                    failures++;
                    $display("[TB] FAIL long_cmd_vec byte %h cycle %0d: got %h required %h", bytes[k], c, dutVec(), expVec());
                end
                if (bus.ack1 === 1'b1) begin acks++; bus.req1 = 1'b0; end
                if (bus.busy === 1'b1) busyCount++;
            end
            checks++;
            if (busyCount != wantB[k] || acks != 1) begin
                failures++;
                $display("[TB] FAIL long_cmd_busy byte %h: busy %0d acks %0d, required %0d and 1", bytes[k], busyCount, acks, wantB[k]);
            end
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        logic [7:0] prevDb;
        applyReset();
        waitIdle();
        applyStimulus(0, 1'b1, 8'hA0);
        applyStimulus(1, 1'b1, 8'hB0);
        prevDb = bus.lcd_db;
        for (int c = 1; c <= 80 && order.size() < 4; c++) begin
            @(negedge clk);
            checks++;
            if (dutVec() !== expVec()) begin
                failures++;
                $display("[TB] FAIL rr_vec cycle %0d: got %h required %h", c, dutVec(), expVec());
            end
            checks++;
            if (bus.lcd_db !== prevDb && bus.ack0 !== 1'b1 && bus.ack1 !== 1'b1) begin
                failures++;
                $display("[TB] FAIL rr_db_change cycle %0d: db %h changed from %h without ack", c, bus.lcd_db, prevDb);
            end
            prevDb = bus.lcd_db;
            if (bus.ack0 === 1'b1) begin order.push_back(0); bus.data0 = bus.data0 + 8'h01; end
            if (bus.ack1 === 1'b1) begin order.push_back(1); bus.data1 = bus.data1 + 8'h01; end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        checks++;
        if (order.size() != 4) begin
            failures++;
            $display("[TB] FAIL rr_grants: got %0d grants required 4", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            checks++;
            if (order[i] != (i % 2)) begin
                failures++;
                $display("[TB] FAIL rr_order grant %0d: got %0d required %0d", i, order[i], i % 2);
            end
        end
    endtask

    task automatic test_withdrawn();
        int ack1Count = 0;
        int rises = 0;
        logic prevEn = 1'b0;
        waitIdle();
        applyStimulus(0, 1'b1, 8'h55);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            checks++;
            if (dutVec() !== expVec()) begin
                failures++;
                $display("[TB] FAIL withdrawn_vec cycle %0d: got %h required %h", c, dutVec(), expVec());
            end
            if (bus.ack0 === 1'b1) bus.req0 = 1'b0;
            if (bus.ack1 === 1'b1) ack1Count++;
            if (bus.lcd_en === 1'b1 && prevEn === 1'b0) rises++;
            prevEn = bus.lcd_en;
            if (c == 4) applyStimulus(1, 1'b1, 8'h99);
            if (c == 6) bus.req1 = 1'b0;
        end
        checks++;
        if (ack1Count != 0 || rises != 1 || bus.lcd_db !== 8'h55) begin
            failures++;
            $display("[TB] FAIL withdrawn: ack1=%0d strobes=%0d db=%h, required 0, 1, 55", ack1Count, rises, bus.lcd_db);
        end
    endtask

    task automatic test_reset_midstrobe();
        int n = 0;
        int acks = 0;
        waitIdle();
        applyStimulus(0, 1'b1, 8'h77);
        while (bus.lcd_en !== 1'b1 && n < 20) begin
            @(negedge clk);
            if (bus.ack0 === 1'b1) bus.req0 = 1'b0;
            n++;
        end
        checks++;
        if (bus.lcd_en !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midstrobe_en_timeout: lcd_en=%b required 1", bus.lcd_en);
        end
        #2;
        rst_n = 1'b0;
        bus.req0 = 1'b0;
        #1;
        checks++;
        if ({bus.lcd_en, bus.lcd_db, bus.busy, bus.ack0} !== {1'b0, 8'h00, HW, 1'b0}) begin
            failures++;
            $display("[TB] FAIL midstrobe_reset: en=%b db=%h busy=%b ack0=%b required 0 00 %b 0",
                     bus.lcd_en, bus.lcd_db, bus.busy, bus.ack0, HW);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        waitIdle();
        applyStimulus(1, 1'b1, 8'h5A);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            checks++;
            if (dutVec() !== expVec()) begin
                failures++;
                $display("[TB] FAIL post_reset_vec cycle %0d: got %h required %h", c, dutVec(), expVec());
            end
            if (bus.ack1 === 1'b1) begin acks++; bus.req1 = 1'b0; end
        end
        checks++;
        if (acks != 1 || bus.lcd_db !== 8'h5A) begin
            failures++;
            $display("[TB] FAIL post_reset_service: acks=%0d db=%h required 1 and 5A", acks, bus.lcd_db);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            checks++;
            if (dutVec() !== expVec()) begin
                failures++;
                $display("[TB] FAIL random_vec cycle %0d: got %h required %h", c, dutVec(), expVec());
            end
            if (bus.req0 === 1'b1) begin
                if (bus.ack0 === 1'b1) begin
                    if ($urandom_range(1, 0) == 1) applyStimulus(0, 1'($urandom_range(1, 0)), randByte());
                    else bus.req0 = 1'b0;
                end else if ($urandom_range(39, 0) == 0) begin
                    bus.req0 = 1'b0;
                end
            end else if ($urandom_range(5, 0) == 0) begin
                applyStimulus(0, 1'($urandom_range(1, 0)), randByte());
            end
            if (bus.req1 === 1'b1) begin
                if (bus.ack1 === 1'b1) begin
                    if ($urandom_range(1, 0) == 1) applyStimulus(1, 1'($urandom_range(1, 0)), randByte());
                    else bus.req1 = 1'b0;
                end else if ($urandom_range(39, 0) == 0) begin
                    bus.req1 = 1'b0;
                end
            end else if ($urandom_range(5, 0) == 0) begin
                applyStimulus(1, 1'($urandom_range(1, 0)), randByte());
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    // Run every scenario in order, then report.
    initial begin
        applyReset();
        test_reset();
`ifdef LCD_HW_RESET_EN
        test_hw_reset();
`endif
        test_single_write();
        test_long_command();
        test_round_robin();
        test_withdrawn();
        test_reset_midstrobe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
- Shares the 8-bit parallel LCD write bus (lcd_en/lcd_rs/lcd_rw/lcd_db/lcd_rst) between two requesters, e.g. the game-status writer and the timer/score writer.
- Accepts one command or data byte per handshake and arbitrates round-robin.
- Generates the enable strobe with programmable setup, pulse and hold timing.
- Enforces the controller execution delay before the next access.
- Sits between the display sequencers and the LCD pins in the top level.

Parameters:
- SETUP_CYC, 4: cycles that lcd_rs/lcd_db are stable before lcd_en rises (min 1).
- PULSE_CYC, 16: cycles lcd_en is held high (min 1).
- HOLD_CYC, 4: cycles lcd_rs/lcd_db are held after lcd_en falls (min 1).
- EXEC_CYC, 2000: post-strobe wait for normal commands and data (min 1).
- LONG_CYC, 80000: post-strobe wait for clear/home commands (min 1).
- RST_CYC, 500000: lcd_rst low time; used only with LCD_HW_RESET_EN.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- req0, input, 1: requester 0 write request. Level; held until ack0.
- rs0, input, 1: requester 0 register select (0 = command, 1 = data).
- data0, input, 8: requester 0 byte.
- ack0, output, 1: one-cycle pulse; requester 0 byte captured.
- req1, input, 1: requester 1 write request.
- rs1, input, 1: requester 1 register select.
- data1, input, 8: requester 1 byte.
- ack1, output, 1: one-cycle pulse; requester 1 byte captured.
- busy, output, 1: high whenever state is not IDLE.
- lcd_en, output, 1: LCD enable strobe.
- lcd_rs, output, 1: LCD register select.
- lcd_rw, output, 1: always 0 (write only).
- lcd_db, output, 8: LCD data bus.
- lcd_rst, output, 1: LCD hardware reset, active-low.

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low on rst_n.
- Reset values: lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_db=0x00, ack0=0, ack1=0, busy=0, lcd_rst=1, state=IDLE, round-robin pointer favours requester 0. All outputs are registered.
- lcd_en is forced low immediately when rst_n is asserted, including mid-strobe. The interrupted transaction is discarded and never acked again.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT (plus RESET with the optional feature).
- IDLE, no request: stays in IDLE.
- IDLE, request present: at the clock edge, grant the winner.
  - Assert ackN for exactly one cycle.
  - Latch rsN to lcd_rs and dataN to lcd_db.
  - Go to SETUP with the counter loaded to SETUP_CYC-1.
- Requests are sampled only in IDLE. The grant is the only capture point, so requesters may change rs/data freely after ackN.
- Arbitration:
  - One requester: it wins.
  - Both requesting: the requester not granted last wins.
  - Pointer updates only on a grant.
  - A req dropped before its ack is a withdrawn request: no transaction.
- SETUP: lcd_en=0 for SETUP_CYC cycles, then PULSE.
- PULSE: lcd_en=1 for PULSE_CYC cycles, then HOLD.
- HOLD: lcd_en=0 for HOLD_CYC cycles. lcd_rs/lcd_db are unchanged. Then WAIT.
- WAIT: lasts LONG_CYC cycles if the latched lcd_rs=0 and the latched byte is 0x01, 0x02 or 0x03 (clear/home). Otherwise it lasts EXEC_CYC cycles. Then IDLE.
- Outputs between transactions: lcd_rs/lcd_db keep their last values.
- Latency: ack and new bus values appear 1 cycle after req is sampled in IDLE. lcd_en rises SETUP_CYC cycles after ack.
- Back-to-back period: 1+SETUP_CYC+PULSE_CYC+HOLD_CYC+wait cycles, where wait is EXEC_CYC or LONG_CYC.
- busy is 0 only in IDLE.
- Counters: one down-counter sized ceil(log2(max of all *_CYC)) bits. It reloads on every state entry. No wrap-around is permitted.

Optional Feature:
- Macro: LCD_HW_RESET_EN.
- Defined:
  - After rst_n deasserts, the FSM enters RESET.
  - lcd_rst=0 for RST_CYC cycles, then lcd_rst=1 and the FSM moves to IDLE.
  - busy=1 throughout RESET. Requests are ignored, with no acks.
  - Reset value of busy is 1 and of lcd_rst is 0.
- Undefined: lcd_rst is tied to 1, there is no RESET state, and the FSM starts in IDLE.

Test Plan:
- Bench parameters for all scenarios: SETUP_CYC=2, PULSE_CYC=3, HOLD_CYC=2, EXEC_CYC=5, LONG_CYC=20, RST_CYC=8.
- Single data write: req0=1, rs0=1, data0=0x41 in IDLE -> ack0 pulses 1 cycle later; lcd_rs=1, lcd_db=0x41; lcd_en high for 3 cycles starting 2 cycles after ack0; busy high for 12 cycles; next grant possible 13 cycles after the first.
- Long command: req1=1, rs1=0, data1=0x01 -> WAIT lasts 20 cycles; busy high for 27 cycles. Repeat with data1=0x38 -> WAIT lasts 5 cycles.
- Round-robin: req0 and req1 both held high continuously -> grants alternate 0,1,0,1 with the first grant to 0. Each ack is one cycle wide; no overlap; lcd_db switches only at ack.
- Withdrawn request: req1 pulsed high for 2 cycles while busy, then dropped -> no ack1 and no strobe for requester 1.
- Reset mid-strobe: assert rst_n=0 while lcd_en=1 -> lcd_en=0, lcd_db=0x00, busy=0 in the same cycle. After release, the next request is serviced normally.
- With LCD_HW_RESET_EN: after reset release, lcd_rst=0 and busy=1 for 8 cycles. A req0 held during this time is acked only after lcd_rst rises.
